t01_input_arbiter: RTL and testbench
====================================

Name: t01_input_arbiter

Overview:
- Sits between the four button debouncers plus the soft-drop button and the Tetris game FSM.
- Converts debounced button levels into single-cycle-accurate action requests.
- Queues one pending flag per action, arbitrates with fixed priority, and offers one action at a time over a valid/ready handshake.
- Generates delayed auto-repeat (DAS/ARR) for held left/right.

Parameters:
- DAS_DELAY, 4000000, clocks a left/right button must stay held after a grant before the first repeat (160 ms at 25 MHz).
- ARR_PERIOD, 1250000, clocks between subsequent repeats while held (50 ms at 25 MHz).
- CNT_W, 23, width of the repeat counter; must hold max(DAS_DELAY, ARR_PERIOD).

Ports:
- clk  in  1  system clock (25 MHz).
- rst_n  in  1  asynchronous active-low reset.
- play_en  in  1  high while the game is in its playing state; low flushes the arbiter.
- btn_right  in  1  debounced level, move right.
- btn_left  in  1  debounced level, move left.
- btn_rot_r  in  1  debounced level, rotate clockwise.
- btn_rot_l  in  1  debounced level, rotate counter-clockwise.
- btn_drop  in  1  debounced level, one-row drop.
- act_ready  in  1  game FSM accepts the offered action this cycle.
- act_valid  out  1  an action is offered.
- act_code  out  3  action code: 0 none, 1 right, 2 left, 3 rot_r, 4 rot_l, 5 drop.
- pending  out  5  pending flags {drop, rot_l, rot_r, left, right}.
- repeat_active  out  1  auto-repeat tracker is in DAS or ARR.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0, all pending flags are 0, edge registers are 0, arbiter is IDLE, tracker is R_OFF, counter is 0.
- Edge detect: each button has a registered previous value. A rising edge (btn high, prev low) sets that button's pending bit at the next clock edge.
  - A rise while the bit is already set coalesces: the bit stays 1.
- Arbiter FSM, IDLE:
  - If play_en and any pending bit is set, select the highest priority: rot_r > rot_l > right > left > drop.
  - Register act_code, assert act_valid, go to OFFER.
  - Latency: act_valid rises exactly 2 clocks after the clock that first samples the button high.
- Arbiter FSM, OFFER:
  - act_valid and act_code are held stable until act_valid & act_ready.
  - On transfer, clear the granted pending bit, drop act_valid, return to IDLE.
  - Minimum one idle cycle between offers.
  - A new rise of the granted button in the transfer cycle re-sets the bit (set wins over clear).
- Repeat tracker (left/right only; tracks the most recently granted horizontal direction):
  - R_OFF: on a grant of right or left whose button is still high, load counter = DAS_DELAY-1 and go to R_DAS.
  - R_DAS/R_ARR: decrement the counter each clock.
    - At 0 with the tracked button still high, set its pending bit, reload ARR_PERIOD-1, go to R_ARR.
    - Tracked button low at any time → R_OFF, counter cleared.
  - A grant of the opposite direction retargets the tracker and reloads DAS_DELAY-1.
  - Rotate and drop grants do not affect the tracker.
- play_en low: pending cleared, tracker to R_OFF, arbiter to IDLE, act_valid low next clock. An in-flight OFFER is aborted, not completed.
  - Edge registers keep tracking, so a button held across play_en rising does not fire until it is released and pressed again.
- Simultaneous left and right rises: both become pending and are issued right then left.
- act_code is 0 whenever act_valid is 0.

Optional Feature:
- Macro T01_ARB_STATS_EN.
- Defined: adds output coalesce_cnt (8 bits). It increments, saturating at 255, each cycle a rising edge or repeat hits an already-set pending bit. It is cleared by reset only.
- Undefined: no port, no counter; behaviour is otherwise identical.

Test Plan:
- Reset then play_en=1, pulse btn_rot_r high at cycle 10, act_ready=1 → act_valid=1 with act_code=3 at cycle 12 for one cycle, pending returns to 0.
- btn_rot_l, btn_right, btn_drop rise in the same cycle, act_ready=1 → codes 4, 1, 5 issued in that order, each 2 cycles apart.
- act_ready held 0 for 20 cycles while offering code 2 → act_valid and act_code stay stable at 1 and 2 for all 20 cycles. Transfer on the first act_ready=1.
- DAS_DELAY=8, ARR_PERIOD=4, btn_right held 40 cycles → first grant, then repeats pending at grant+8, +12, +16, … Release stops repeats and repeat_active=0 next cycle.
- play_en dropped during OFFER with pending=5'b10010 → next cycle act_valid=0, pending=0. Held buttons do not fire when play_en returns.
- rst_n asserted mid-OFFER asynchronously → act_valid=0 immediately, not waiting for a clock edge. With T01_ARB_STATS_EN, 3 rises of btn_left before any grant → coalesce_cnt=2.

Source files
------------

// File: rtl/t01_input_arbiter.sv
// Button-to-action arbiter: edge detect, per-action pending flags, fixed-priority
// valid/ready offer, DAS/ARR auto-repeat for left/right. Optional T01_ARB_STATS_EN adds coalesce_cnt.
module t01_input_arbiter #(
  parameter int unsigned DAS_DELAY  = 4000000,
  parameter int unsigned ARR_PERIOD = 1250000,
  parameter int unsigned CNT_W      = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       play_en,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic       btn_rot_r,
  input  logic       btn_rot_l,
  input  logic       btn_drop,
  input  logic       act_ready,
  output logic       act_valid,
  output logic [2:0] act_code,
  output logic [4:0] pending,
  output logic       repeat_active
`ifdef T01_ARB_STATS_EN
  ,
  output logic [7:0] coalesce_cnt
`endif
);

  localparam int unsigned NBTN = 5;
  localparam logic [CNT_W-1:0] DAS_LOAD = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] ARR_LOAD = CNT_W'(ARR_PERIOD - 1);

  typedef enum logic {A_IDLE, A_OFFER} arb_state_t;
  typedef enum logic [1:0] {R_OFF, R_DAS, R_ARR} rep_state_t;

  logic [NBTN-1:0] btn, btn_prev, rise, rep_set, grant, pend_d;
  arb_state_t      arb_q, arb_d;
  rep_state_t      rep_q, rep_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            valid_d;
  logic [2:0]      code_d, sel_code;
  logic            xfer, hgrant, gdir, gbtn, tracked_btn, retarget, fire;

  // Bit order matches pending: {drop, rot_l, rot_r, left, right}
  assign btn  = {btn_drop, btn_rot_l, btn_rot_r, btn_left, btn_right};
  assign rise = btn & ~btn_prev;
  assign xfer = (arb_q == A_OFFER) & act_ready & play_en;

  // Priority rot_r > rot_l > right > left > drop; code is pending bit index + 1
  always_comb begin
    sel_code = 3'd0;
    if (pending[2])      sel_code = 3'd3;
    else if (pending[3]) sel_code = 3'd4;
    else if (pending[0]) sel_code = 3'd1;
    else if (pending[1]) sel_code = 3'd2;
    else if (pending[4]) sel_code = 3'd5;
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NBTN; i++)
      grant[i] = xfer && (act_code == 3'(i + 1));
  end

  // Arbiter next state
  always_comb begin
    arb_d = arb_q;
    case (arb_q)
      A_IDLE:  if (play_en && (|pending)) arb_d = A_OFFER;
      A_OFFER: if (!play_en || act_ready) arb_d = A_IDLE;
      default: arb_d = A_IDLE;
    endcase
  end

  // Arbiter outputs; the offer is held until transfer or flush
  always_comb begin
    valid_d = 1'b0;
    code_d  = 3'd0;
    case (arb_q)
      A_IDLE: if (play_en && (|pending)) begin
        valid_d = 1'b1;
        code_d  = sel_code;
      end
      A_OFFER: if (play_en && !act_ready) begin
        valid_d = 1'b1;
        code_d  = act_code;
      end
      default: ;
    endcase
  end

  assign hgrant      = grant[0] | grant[1];
  assign gdir        = grant[1];
  assign gbtn        = gdir ? btn_left : btn_right;
  assign tracked_btn = dir_q ? btn_left : btn_right;
  assign retarget    = play_en && hgrant && gbtn && ((rep_q == R_OFF) || (gdir != dir_q));
  assign fire        = play_en && !retarget && (rep_q != R_OFF) && tracked_btn && (cnt_q == '0);

  // Repeat tracker next state
  always_comb begin
    rep_d = rep_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!play_en) begin
      rep_d = R_OFF;
      cnt_d = '0;
    end else if (retarget) begin
      rep_d = R_DAS;
      cnt_d = DAS_LOAD;
      dir_d = gdir;
    end else if (rep_q != R_OFF) begin
      if (!tracked_btn) begin
        rep_d = R_OFF;
        cnt_d = '0;
      end else if (fire) begin
        rep_d = R_ARR;
        cnt_d = ARR_LOAD;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Repeat tracker output: re-arm the tracked direction's pending bit
  always_comb begin
    rep_set = '0;
    if (fire) begin
      if (dir_q) rep_set[1] = 1'b1;
      else       rep_set[0] = 1'b1;
    end
  end

  // Set wins over the grant clear
  assign pend_d = play_en ? ((pending & ~grant) | rise | rep_set) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev      <= '0;
      pending       <= '0;
      arb_q         <= A_IDLE;
      act_valid     <= 1'b0;
      act_code      <= 3'd0;
      rep_q         <= R_OFF;
      cnt_q         <= '0;
      dir_q         <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      btn_prev      <= btn;
      pending       <= pend_d;
      arb_q         <= arb_d;
      act_valid     <= valid_d;
      act_code      <= code_d;
      rep_q         <= rep_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      repeat_active <= (rep_d != R_OFF);
    end
  end

`ifdef T01_ARB_STATS_EN
  // Counts cycles where a new request lands on an already-pending action
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      coalesce_cnt <= 8'd0;
    else if ((|((rise | rep_set) & pending)) && (coalesce_cnt != 8'hFF))
      coalesce_cnt <= coalesce_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_t01_input_arbiter.sv
// Directed bench for t01_input_arbiter with short DAS/ARR; define T01_ARB_STATS_EN to cover coalesce_cnt.
module tb_t01_input_arbiter;

  logic       clk = 1'b0;
  logic       rst_n, play_en, act_ready;
  logic       btn_right, btn_left, btn_rot_r, btn_rot_l, btn_drop;
  logic       act_valid, repeat_active;
  logic [2:0] act_code;
  logic [4:0] pending;
`ifdef T01_ARB_STATS_EN
  logic [7:0] coalesce_cnt;
`endif

  int total = 0;
  int bad   = 0;

  t01_input_arbiter #(.DAS_DELAY(8), .ARR_PERIOD(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .play_en(play_en),
    .btn_right(btn_right), .btn_left(btn_left), .btn_rot_r(btn_rot_r),
    .btn_rot_l(btn_rot_l), .btn_drop(btn_drop), .act_ready(act_ready),
    .act_valid(act_valid), .act_code(act_code), .pending(pending),
    .repeat_active(repeat_active)
`ifdef T01_ARB_STATS_EN
    , .coalesce_cnt(coalesce_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; play_en = 1'b0; act_ready = 1'b0;
    btn_right = 1'b0; btn_left = 1'b0; btn_rot_r = 1'b0; btn_rot_l = 1'b0; btn_drop = 1'b0;
    repeat (3) tick;
    chk("rst_valid", 32'(act_valid), 32'd0);
    chk("rst_code", 32'(act_code), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_repeat", 32'(repeat_active), 32'd0);
    rst_n = 1'b1; play_en = 1'b1; act_ready = 1'b1;
    tick;

    // Single rot_r pulse: pending next edge, offer one edge later
    btn_rot_r = 1'b1; tick;
    chk("t1_pend", 32'(pending), 32'h04);
    chk("t1_nov", 32'(act_valid), 32'd0);
    btn_rot_r = 1'b0; tick;
    chk("t1_valid", 32'(act_valid), 32'd1);
    chk("t1_code", 32'(act_code), 32'd3);
    tick;
    chk("t1_drop", 32'(act_valid), 32'd0);
    chk("t1_code0", 32'(act_code), 32'd0);
    chk("t1_clr", 32'(pending), 32'd0);
    tick;

    // Three simultaneous rises: rot_l, right, drop
    btn_rot_l = 1'b1; btn_right = 1'b1; btn_drop = 1'b1; tick;
    chk("t2_pend", 32'(pending), 32'h19);
    btn_rot_l = 1'b0; btn_right = 1'b0; btn_drop = 1'b0;
    tick; chk("t2_c4", 32'(act_code), 32'd4); chk("t2_v4", 32'(act_valid), 32'd1);
    tick; chk("t2_gap1", 32'(act_valid), 32'd0); chk("t2_pend2", 32'(pending), 32'h11);
    tick; chk("t2_c1", 32'(act_code), 32'd1);
    tick; chk("t2_gap2", 32'(act_valid), 32'd0);
    tick; chk("t2_c5", 32'(act_code), 32'd5);
    tick; chk("t2_gap3", 32'(act_valid), 32'd0); chk("t2_pend0", 32'(pending), 32'd0);

    // Back-pressure: offer of left held stable
    act_ready = 1'b0; btn_left = 1'b1; tick;
    btn_left = 1'b0; tick;
    chk("t3_valid", 32'(act_valid), 32'd1);
    chk("t3_code", 32'(act_code), 32'd2);
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("t3_hold_v", 32'(act_valid), 32'd1);
      chk("t3_hold_c", 32'(act_code), 32'd2);
    end
    act_ready = 1'b1; tick;
    chk("t3_xfer", 32'(act_valid), 32'd0);
    chk("t3_clr", 32'(pending), 32'd0);
    tick;

    // Auto-repeat: grant at edge 3, repeats pending at edges 11, 15, 19
    btn_right = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      if (e == 21) btn_right = 1'b0;
      tick;
      case (e)
        2:  chk("t4_rep_pre", 32'(repeat_active), 32'd0);
        3:  begin chk("t4_rep_on", 32'(repeat_active), 32'd1); chk("t4_p3", 32'(pending), 32'd0); end
        10: chk("t4_p10", 32'(pending), 32'd0);
        11: chk("t4_p11", 32'(pending), 32'd1);
        14: chk("t4_p14", 32'(pending), 32'd0);
        15: chk("t4_p15", 32'(pending), 32'd1);
        18: chk("t4_p18", 32'(pending), 32'd0);
        19: chk("t4_p19", 32'(pending), 32'd1);
        21: chk("t4_rep_off", 32'(repeat_active), 32'd0);
        24: begin chk("t4_p24", 32'(pending), 32'd0); chk("t4_v24", 32'(act_valid), 32'd0); end
        default: ;
      endcase
    end
    tick;

    // play_en drop aborts an offer; held buttons stay silent afterwards
    act_ready = 1'b0; btn_left = 1'b1; btn_drop = 1'b1;
    tick; tick;
    chk("t5_pend", 32'(pending), 32'h12);
    chk("t5_valid", 32'(act_valid), 32'd1);
    chk("t5_code", 32'(act_code), 32'd2);
    play_en = 1'b0; tick;
    chk("t5_abort_v", 32'(act_valid), 32'd0);
    chk("t5_abort_c", 32'(act_code), 32'd0);
    chk("t5_abort_p", 32'(pending), 32'd0);
    tick; play_en = 1'b1;
    repeat (4) tick;
    chk("t5_held_p", 32'(pending), 32'd0);
    chk("t5_held_v", 32'(act_valid), 32'd0);
    btn_left = 1'b0; btn_drop = 1'b0; act_ready = 1'b1; tick;

    // Asynchronous reset in the middle of an offer
    act_ready = 1'b0; btn_rot_l = 1'b1; tick;
    btn_rot_l = 1'b0; tick;
    chk("t6_valid", 32'(act_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_v", 32'(act_valid), 32'd0);
    chk("t6_async_c", 32'(act_code), 32'd0);
    chk("t6_async_p", 32'(pending), 32'd0);
    tick; rst_n = 1'b1; tick;

`ifdef T01_ARB_STATS_EN
    for (int i = 0; i < 3; i++) begin
      btn_left = 1'b1; tick;
      btn_left = 1'b0; tick;
    end
    chk("t7_coalesce", 32'(coalesce_cnt), 32'd2);
    chk("t7_pend", 32'(pending), 32'h02);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
